cushion_queue: RTL and testbench

//  Parametrised successor to the single-entry exec->mread cushion register: a DEPTH-entry
//  in-order queue between the execute stage and the memory-read stage. Carries one packed

---
 rtl/cushion_queue.sv | 94 +++++++++
 tb/tb_cushion_queue.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/cushion_queue.sv
// cushion_queue: DEPTH-entry in-order queue between execute and memory-read stages.
// Optional combinational empty-queue bypass when CUSHION_BYPASS_EN is defined.
module cushion_queue #(
    parameter int unsigned WIDTH       = 160,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned AFULL_LEVEL = 3
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     FLUSH,
    input  logic                     MEM_WAIT,
    input  logic                     IN_VALID,
    input  logic [WIDTH-1:0]         IN_DATA,
    output logic                     IN_READY,
    output logic                     OUT_VALID,
    output logic [WIDTH-1:0]         OUT_DATA,
    input  logic                     OUT_READY,
    output logic [$clog2(DEPTH):0]   COUNT,
    output logic                     ALMOST_FULL
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W  = ADDR_W + 1;

    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_wr_en;
    logic w_rd_en;
    logic w_bypass_take;

    assign w_empty     = (r_count == '0);
    assign IN_READY    = (r_count != CNT_W'(DEPTH));
    assign COUNT       = r_count;
    assign ALMOST_FULL = (r_count >= CNT_W'(AFULL_LEVEL));

`ifdef CUSHION_BYPASS_EN
    logic w_bypass;
    assign w_bypass  = w_empty & IN_VALID & ~FLUSH;
    assign OUT_VALID = ~w_empty | w_bypass;
    always_comb begin
        OUT_DATA = '0;
        if (!w_empty)
            OUT_DATA = r_mem[r_rd_ptr];
        else if (w_bypass)
            OUT_DATA = IN_DATA;
    end
    assign w_pop         = OUT_VALID & OUT_READY & ~MEM_WAIT & ~FLUSH;
    // A bypassed bundle consumed the same cycle never touches storage or pointers.
    assign w_bypass_take = w_bypass & w_pop;
`else
    assign OUT_VALID     = ~w_empty;
    assign OUT_DATA      = w_empty ? '0 : r_mem[r_rd_ptr];
    assign w_pop         = OUT_VALID & OUT_READY & ~MEM_WAIT & ~FLUSH;
    assign w_bypass_take = 1'b0;
`endif

    assign w_push  = IN_VALID & IN_READY & ~FLUSH;
    assign w_wr_en = w_push & ~w_bypass_take;
    assign w_rd_en = w_pop  & ~w_bypass_take;

    always_ff @(posedge CLK) begin
        if (w_wr_en)
            r_mem[r_wr_ptr] <= IN_DATA;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (FLUSH) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_en)
                r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            if (w_rd_en)
                r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            case ({w_wr_en, w_rd_en})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_cushion_queue.sv
// Directed self-checking bench for cushion_queue (DEPTH=4, AFULL_LEVEL=3).
module tb_cushion_queue;

    localparam int unsigned WIDTH = 160;

    logic             CLK;
    logic             RST;
    logic             FLUSH;
    logic             MEM_WAIT;
    logic             IN_VALID;
    logic [WIDTH-1:0] IN_DATA;
    logic             IN_READY;
    logic             OUT_VALID;
    logic [WIDTH-1:0] OUT_DATA;
    logic             OUT_READY;
    logic [2:0]       COUNT;
    logic             ALMOST_FULL;

    int n_checks = 0;
    int n_fail   = 0;

    cushion_queue #(.WIDTH(WIDTH), .DEPTH(4), .AFULL_LEVEL(3)) dut (
        .CLK(CLK), .RST(RST), .FLUSH(FLUSH), .MEM_WAIT(MEM_WAIT),
        .IN_VALID(IN_VALID), .IN_DATA(IN_DATA), .IN_READY(IN_READY),
        .OUT_VALID(OUT_VALID), .OUT_DATA(OUT_DATA), .OUT_READY(OUT_READY),
        .COUNT(COUNT), .ALMOST_FULL(ALMOST_FULL)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST = 1'b0; FLUSH = 1'b0; MEM_WAIT = 1'b0;
        IN_VALID = 1'b0; IN_DATA = '0; OUT_READY = 1'b0;
        #3;
        chk("rst_count", WIDTH'(COUNT), WIDTH'(0));
        chk("rst_ovalid", WIDTH'(OUT_VALID), WIDTH'(0));
        chk("rst_odata", OUT_DATA, '0);
        chk("rst_iready", WIDTH'(IN_READY), WIDTH'(1));
        chk("rst_afull", WIDTH'(ALMOST_FULL), WIDTH'(0));
        @(negedge CLK);
        RST = 1'b1;
        cyc();

        // Fill to full with no consumer.
        IN_VALID = 1'b1;
        for (int i = 0; i < 4; i++) begin
            IN_DATA = WIDTH'(32'hA + i);
            cyc();
            chk("fill_count", WIDTH'(COUNT), WIDTH'(i + 1));
            chk("fill_afull", WIDTH'(ALMOST_FULL), WIDTH'(i + 1 >= 3));
            chk("fill_head", OUT_DATA, WIDTH'(32'hA));
        end
        chk("full_iready", WIDTH'(IN_READY), WIDTH'(0));
        // Full with pop and offer: no pass-through, 0xE is refused.
        IN_DATA = WIDTH'(32'hE); OUT_READY = 1'b1;
        #1;
        chk("full_iready_pop", WIDTH'(IN_READY), WIDTH'(0));
        cyc();
        IN_VALID = 1'b0;
        chk("full_pop_count", WIDTH'(COUNT), WIDTH'(3));
        for (int i = 1; i < 4; i++) begin
            chk("drain_data", OUT_DATA, WIDTH'(32'hA + i));
            cyc();
        end
        chk("drain_count", WIDTH'(COUNT), WIDTH'(0));
        chk("drain_ovalid", WIDTH'(OUT_VALID), WIDTH'(0));
        chk("drain_odata", OUT_DATA, '0);

        // Pointer wrap: 3 pushes, then 3 push+pop, then drain.
        IN_VALID = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            IN_DATA = WIDTH'(32'h10 + i);
            OUT_READY = (i > 3);
            #1;
            if (i > 3) chk("wrap_head", OUT_DATA, WIDTH'(32'h10 + i - 3));
            cyc();
            chk("wrap_count", WIDTH'(COUNT), WIDTH'((i > 3) ? 3 : i));
        end
        IN_VALID = 1'b0;
        for (int i = 4; i <= 6; i++) begin
            chk("wrap_drain", OUT_DATA, WIDTH'(32'h10 + i));
            cyc();
        end
        chk("wrap_empty", WIDTH'(COUNT), WIDTH'(0));

        // MEM_WAIT holds the head while pushes continue.
        OUT_READY = 1'b0; IN_VALID = 1'b1;
        IN_DATA = WIDTH'(32'h21); cyc();
        IN_DATA = WIDTH'(32'h22); cyc();
        chk("mw_start", WIDTH'(COUNT), WIDTH'(2));
        MEM_WAIT = 1'b1; OUT_READY = 1'b1;
        for (int i = 0; i < 3; i++) begin
            IN_DATA = WIDTH'(32'h23 + i);
            #1;
            chk("mw_iready", WIDTH'(IN_READY), WIDTH'(i < 2));
            chk("mw_head", OUT_DATA, WIDTH'(32'h21));
            cyc();
            chk("mw_count", WIDTH'(COUNT), WIDTH'((i < 2) ? 3 + i : 4));
        end
        MEM_WAIT = 1'b0; IN_VALID = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("mw_drain", OUT_DATA, WIDTH'(32'h21 + i));
            cyc();
        end
        chk("mw_empty", WIDTH'(COUNT), WIDTH'(0));

        // FLUSH discards contents and the same-cycle push.
        OUT_READY = 1'b0; IN_VALID = 1'b1;
        for (int i = 0; i < 3; i++) begin
            IN_DATA = WIDTH'(32'h31 + i);
            cyc();
        end
        chk("fl_pre", WIDTH'(COUNT), WIDTH'(3));
        IN_DATA = WIDTH'(32'h34); FLUSH = 1'b1; OUT_READY = 1'b1;
        cyc();
        FLUSH = 1'b0; OUT_READY = 1'b0;
        chk("fl_count", WIDTH'(COUNT), WIDTH'(0));
        chk("fl_ovalid", WIDTH'(OUT_VALID), WIDTH'(0));
        chk("fl_odata", OUT_DATA, '0);
        IN_DATA = WIDTH'(32'h55);
        cyc();
        IN_VALID = 1'b0;
        chk("fl_new_count", WIDTH'(COUNT), WIDTH'(1));
        chk("fl_new_head", OUT_DATA, WIDTH'(32'h55));
        OUT_READY = 1'b1;
        cyc();
        chk("fl_new_pop", WIDTH'(COUNT), WIDTH'(0));

        // Empty queue with simultaneous offer and consume.
        IN_VALID = 1'b1; IN_DATA = WIDTH'(32'h77);
        #1;
`ifdef CUSHION_BYPASS_EN
        chk("bp_ovalid", WIDTH'(OUT_VALID), WIDTH'(1));
        chk("bp_odata", OUT_DATA, WIDTH'(32'h77));
        cyc();
        IN_VALID = 1'b0;
        chk("bp_count", WIDTH'(COUNT), WIDTH'(0));
`else
        chk("nb_ovalid", WIDTH'(OUT_VALID), WIDTH'(0));
        chk("nb_odata", OUT_DATA, '0);
        cyc();
        IN_VALID = 1'b0;
        chk("nb_count", WIDTH'(COUNT), WIDTH'(1));
        chk("nb_odata_next", OUT_DATA, WIDTH'(32'h77));
        cyc();
        chk("nb_pop", WIDTH'(COUNT), WIDTH'(0));
`endif

        // Asynchronous reset mid-stream at COUNT=3.
        OUT_READY = 1'b0; IN_VALID = 1'b1;
        for (int i = 0; i < 3; i++) begin
            IN_DATA = WIDTH'(32'h41 + i);
            cyc();
        end
        IN_VALID = 1'b0;
        chk("ar_pre", WIDTH'(COUNT), WIDTH'(3));
        #2;
        RST = 1'b0;
        #1;
        chk("ar_count", WIDTH'(COUNT), WIDTH'(0));
        chk("ar_ovalid", WIDTH'(OUT_VALID), WIDTH'(0));
        chk("ar_odata", OUT_DATA, '0);
        chk("ar_iready", WIDTH'(IN_READY), WIDTH'(1));
        chk("ar_afull", WIDTH'(ALMOST_FULL), WIDTH'(0));
        @(negedge CLK);
        RST = 1'b1;
        cyc();
        chk("ar_after", WIDTH'(COUNT), WIDTH'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
